// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its grant consumer.
package arb_pkg;

    localparam int ARB_N  = 3;
    localparam int ARB_IW = $clog2(ARB_N);

    // Index of the lowest set bit; returns 0 for an all-zero vector.
    function automatic logic [ARB_IW-1:0] onehot_to_idx(input logic [ARB_N-1:0] v);
        logic [ARB_IW-1:0] idx;
        idx = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ARB_IW'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [ARB_N-1:0] v);
        return (v != '0) && ((v & (v - ARB_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer. Head drives the outputs, skid holds the
// second entry. The producer must not push while count is 2.
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    // Next-state for the two entries and the occupancy counter.
    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        pop     = (count_q != 2'd0) && out_ready;

        if (pop && (count_q == 2'd2)) begin
            head_d = skid_q;
        end

        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                head_d = push_data;
            end else if (count_q == 2'd1) begin
                skid_d = push_data;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Entry and counter registers; reset discards anything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

endmodule

// File: rtl/arb_grant_mux.sv
// Consumer of the round-robin arbiter's one-hot grant: gates arbiter
// requests on buffer space, muxes the winner's payload into a 2-entry
// skid buffer and flags grant protocol errors.
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready, and a held-off output keeps
// out_data/out_id stable until accepted.
module arb_grant_mux
    import arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    arb_req,
    input  logic [N-1:0]    arb_grant,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [IW-1:0]   out_id,
    input  logic            out_ready,
    output logic            grant_err
);

    logic [1:0]       count;
    logic             accept_en;
    logic             push;
    logic [IW-1:0]    sel_idx;
    logic [DW-1:0]    sel_data;
    logic [IW+DW-1:0] buf_out;
    logic             grant_err_q, grant_err_d;

    // Space gating uses registered occupancy only, so out_ready never reaches
    // arb_req/req_ready. rst_n is folded in so clients see no accept in reset.
    assign accept_en = rst_n && (count != 2'd2);
    assign arb_req   = accept_en ? req_valid : '0;
    assign req_ready = arb_grant & {N{accept_en}};

    // Winner selection; lowest set bit wins if the grant is malformed.
    always_comb begin
        sel_idx  = onehot_to_idx(arb_grant);
        sel_data = req_data[sel_idx*DW +: DW];
        push     = accept_en && (arb_grant != '0);
    end

    // Sticky error: malformed grant, or grant to a client not requesting.
    always_comb begin
        grant_err_d = grant_err_q;
        if ((arb_grant != '0) && (!is_onehot(arb_grant) || !req_valid[sel_idx])) begin
            grant_err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= grant_err_d;
        end
    end

    skid_buf2 #(
        .W(IW + DW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({sel_idx, sel_data}),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (buf_out),
        .count    (count)
    );

    assign out_data  = buf_out[DW-1:0];
    assign out_id    = buf_out[DW +: IW];
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux driven by a behavioural 3-way
// round-robin arbiter whose grant can be overridden.
module tb_arb_grant_mux;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready;
    logic            grant_err;

    int checks   = 0;
    int failures = 0;

    // Arbiter model: priority starts at ptr, advances past each winner.
    int           ptr;
    int           model_idx;
    logic [N-1:0] model_grant;
    logic         force_en;
    logic [N-1:0] force_val;

    always_comb begin
        model_grant = '0;
        model_idx   = 0;
        for (int k = 0; k < N; k++) begin
            if (model_grant == '0 && arb_req[(ptr + k) % N]) begin
                model_grant[(ptr + k) % N] = 1'b1;
                model_idx = (ptr + k) % N;
            end
        end
        arb_grant = force_en ? force_val : model_grant;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= 0;
        else if (!force_en && model_grant != '0) ptr <= (model_idx + 1) % N;
    end

    arb_grant_mux #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .arb_req  (arb_req),
        .arb_grant(arb_grant),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_ready(out_ready),
        .grant_err(grant_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_val = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        req_data = {32'hA2, 32'hA1, 32'hA0};

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_grant_err", 32'(grant_err), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_arb_req", 32'(arb_req), 0);

        // Round-robin at full rate
        cyc();
        req_valid = 3'b111;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rr_first_valid", 32'(out_valid), 0);
        chk("rr_first_ready", 32'(req_ready), 32'b001);
        chk("rr_arb_req", 32'(arb_req), 32'b111);
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clk);
            chk("rr_valid", 32'(out_valid), 1);
            chk("rr_id", 32'(out_id), 32'(i % 3));
            chk("rr_data", out_data, 32'hA0 + 32'(i % 3));
        end

        // Backpressure: two pushes, then requests gated, then resume at client 2
        reset_dut();
        req_valid = 3'b111;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready0", 32'(req_ready), 32'b001);
        cyc();
        @(negedge clk);
        chk("bp_id0", 32'(out_id), 0);
        chk("bp_ready1", 32'(req_ready), 32'b010);
        cyc();
        @(negedge clk);
        chk("bp_full_arb_req", 32'(arb_req), 0);
        chk("bp_full_ready", 32'(req_ready), 0);
        chk("bp_hold_id", 32'(out_id), 0);
        chk("bp_hold_data", out_data, 32'hA0);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_comb_path", 32'(arb_req), 0);
        chk("bp_pop_id0", 32'(out_id), 0);
        cyc();
        @(negedge clk);
        chk("bp_pop_id1", 32'(out_id), 1);
        chk("bp_next_grant", 32'(req_ready), 32'b100);
        cyc();
        @(negedge clk);
        chk("bp_id2", 32'(out_id), 2);
        chk("bp_data2", out_data, 32'hA2);

        // Single client
        reset_dut();
        req_valid = 3'b010;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_ready", 32'(req_ready), 32'b010);
            if (i > 0) chk("single_id", 32'(out_id), 1);
            cyc();
        end

        // Protocol error: malformed grant 3'b011
        reset_dut();
        req_valid = 3'b011;
        out_ready = 1'b0;
        force_en  = 1'b1;
        force_val = 3'b011;
        @(negedge clk);
        chk("err_before", 32'(grant_err), 0);
        chk("err_ready", 32'(req_ready), 32'b011);
        cyc();
        force_en  = 1'b0;
        req_valid = 3'b000;
        @(negedge clk);
        chk("err_set", 32'(grant_err), 1);
        chk("err_push_valid", 32'(out_valid), 1);
        chk("err_push_id", 32'(out_id), 0);
        chk("err_push_data", out_data, 32'hA0);
        repeat (2) cyc();
        @(negedge clk);
        chk("err_sticky", 32'(grant_err), 1);

        // Grant to a non-requesting client also flags
        reset_dut();
        req_valid = 3'b010;
        force_en  = 1'b1;
        force_val = 3'b100;
        @(negedge clk);
        chk("err_cleared", 32'(grant_err), 0);
        cyc();
        force_en = 1'b0;
        @(negedge clk);
        chk("err_invalid_client", 32'(grant_err), 1);

        // Reset with a full buffer
        reset_dut();
        req_valid = 3'b111;
        out_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("full_valid", 32'(out_valid), 1);
        chk("full_arb_req", 32'(arb_req), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_data", out_data, 0);
        chk("async_id", 32'(out_id), 0);
        chk("async_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_valid", 32'(out_valid), 0);
        chk("rel_ready", 32'(req_ready), 32'b001);
        cyc();
        @(negedge clk);
        chk("rel_out_valid", 32'(out_valid), 1);
        chk("rel_out_id", 32'(out_id), 0);
        chk("rel_out_data", out_data, 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
